// File: rtl/alu_arbiter.sv
// Shares one execute-stage ALU between the main execute pipe (port 0) and the
// address/branch unit (port 1) with round-robin grant and a single op in flight.
module alu_arbiter #(
    parameter int unsigned WIDTH    = 40,
    parameter int unsigned OPW      = 5,
    parameter bit          RST_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             controlInReqValid0,
    input  logic             controlInReqValid1,
    input  logic [WIDTH-1:0] dataInReqA0,
    input  logic [WIDTH-1:0] dataInReqA1,
    input  logic [WIDTH-1:0] dataInReqB0,
    input  logic [WIDTH-1:0] dataInReqB1,
    input  logic [OPW-1:0]   controlInReqOp0,
    input  logic [OPW-1:0]   controlInReqOp1,
    input  logic             controlInReqShiftDir0,
    input  logic             controlInReqShiftDir1,
    input  logic             controlInReqSetFlags0,
    input  logic             controlInReqSetFlags1,
    output logic             controlOutReqReady0,
    output logic             controlOutReqReady1,
    output logic             controlOutRspValid0,
    output logic             controlOutRspValid1,
    input  logic             controlInRspReady0,
    input  logic             controlInRspReady1,
    output logic [WIDTH-1:0] dataOutRspResult,
    output logic [3:0]       dataOutRspFlags,
    output logic [WIDTH-1:0] dataOutALUa,
    output logic [WIDTH-1:0] dataOutALUb,
    output logic [OPW-1:0]   controlOutALUop,
    output logic             controlOutALUshiftDir,
    input  logic [WIDTH-1:0] dataInALU,
    input  logic             controlInAluZ,
    input  logic             controlInAluC,
    input  logic             controlInAluV,
    input  logic             controlInAluN,
    output logic [3:0]       dataOutFlags,
    output logic             controlOutBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   prio;
    logic   grant;
    logic   setFlagsLatched;
    logic   acceptWindow;
    logic   rspRetire;

    // Ready is combinational so a requester learns of its grant in the same
    // cycle; the prio bit only matters when both ports are asking.
    always_comb begin
        acceptWindow        = (state == IDLE) && !rst;
        controlOutReqReady0 = acceptWindow && controlInReqValid0 && (!prio || !controlInReqValid1);
        controlOutReqReady1 = acceptWindow && controlInReqValid1 && (prio || !controlInReqValid0);
        rspRetire           = grant ? controlInRspReady1 : controlInRspReady0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            prio                  <= RST_PRIO;
            grant                 <= 1'b0;
            setFlagsLatched       <= 1'b0;
            controlOutRspValid0   <= 1'b0;
            controlOutRspValid1   <= 1'b0;
            dataOutRspResult      <= '0;
            dataOutRspFlags       <= '0;
            dataOutALUa           <= '0;
            dataOutALUb           <= '0;
            controlOutALUop       <= '0;
            controlOutALUshiftDir <= 1'b0;
            dataOutFlags          <= '0;
            controlOutBusy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (controlOutReqReady0) begin
                        dataOutALUa           <= dataInReqA0;
                        dataOutALUb           <= dataInReqB0;
                        controlOutALUop       <= controlInReqOp0;
                        controlOutALUshiftDir <= controlInReqShiftDir0;
                        setFlagsLatched       <= controlInReqSetFlags0;
                        grant                 <= 1'b0;
                        controlOutBusy        <= 1'b1;
                        state                 <= EXEC;
                    end else if (controlOutReqReady1) begin
                        dataOutALUa           <= dataInReqA1;
                        dataOutALUb           <= dataInReqB1;
                        controlOutALUop       <= controlInReqOp1;
                        controlOutALUshiftDir <= controlInReqShiftDir1;
                        setFlagsLatched       <= controlInReqSetFlags1;
                        grant                 <= 1'b1;
                        controlOutBusy        <= 1'b1;
                        state                 <= EXEC;
                    end
                end
                // The ALU has had a full cycle on the registered operands, so its
                // combinational result is settled by this edge.
                EXEC: begin
                    dataOutRspResult    <= dataInALU;
                    dataOutRspFlags     <= {controlInAluN, controlInAluZ, controlInAluC, controlInAluV};
                    if (setFlagsLatched) begin
                        dataOutFlags <= {controlInAluN, controlInAluZ, controlInAluC, controlInAluV};
                    end
                    controlOutRspValid0 <= !grant;
                    controlOutRspValid1 <= grant;
                    state               <= RESP;
                end
                RESP: begin
                    if (rspRetire) begin
                        controlOutRspValid0 <= 1'b0;
                        controlOutRspValid1 <= 1'b0;
                        controlOutBusy      <= 1'b0;
                        prio                <= ~grant;
                        state               <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Sequences and shares the single 40-bit execute-stage ALU between two requesters: port 0 (main execute pipe) and port 1 (address/branch unit). Each request carries operands, op, shift direction and a set-flags bit. Valid/ready handshakes on request and response; round-robin grant. Registered ALU drive, registered result/flag capture, and the architectural condition-flag register {N,Z,C,V}.

Parameters:
WIDTH, 40, operand/result width (matches ALU datapath)
OPW, 5, ALU op field width
RST_PRIO, 0, requester holding priority after reset (0 or 1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
controlInReqValid0/1  input  1  request valid, per requester
dataInReqA0/1  input  WIDTH  operand A, per requester
dataInReqB0/1  input  WIDTH  operand B, per requester
controlInReqOp0/1  input  OPW  ALU op, per requester
controlInReqShiftDir0/1  input  1  shift direction, per requester
controlInReqSetFlags0/1  input  1  update flag register with this op's flags
controlOutReqReady0/1  output  1  request accepted this cycle when valid&&ready
controlOutRspValid0/1  output  1  response valid, to granted requester only
controlInRspReady0/1  input  1  requester consumes response
dataOutRspResult  output  WIDTH  shared response result bus
dataOutRspFlags  output  4  shared response flags {N,Z,C,V} of that op
dataOutALUa / dataOutALUb  output  WIDTH  registered ALU operands
controlOutALUop  output  OPW  registered ALU op
controlOutALUshiftDir  output  1  registered shift direction
dataInALU  input  WIDTH  ALU result (combinational from ALU)
controlInAluZ/C/V/N  input  1  ALU flags (combinational)
dataOutFlags  output  4  architectural flag register {N,Z,C,V}
controlOutBusy  output  1  high in EXEC or RESP

Behaviour:
- FSM: IDLE -> EXEC -> RESP -> IDLE; one op in flight max.
- IDLE: ready combinational; ready0 = valid0 && (prio==0 || !valid1); ready1 = valid1 && (prio==1 || !valid0). Never both high. Ready low in EXEC, RESP, and while rst high.
- Handshake in IDLE (valid&&ready): latch A, B, op, shiftDir into ALU drive regs; latch grant id and setFlags; -> EXEC.
- EXEC (one cycle): ALU settles; at end of cycle capture dataInALU into dataOutRspResult, {N,Z,C,V} into dataOutRspFlags; if setFlags latched, also load dataOutFlags; -> RESP.
- RESP: controlOutRspValid[grant]=1, other rspValid=0; result/flags held stable until controlInRspReady[grant]=1; on that edge -> IDLE, prio <= ~grant.
- Latency: handshake at edge N -> rspValid high from cycle N+2. Minimum 3 cycles per op. New request cannot be accepted in the cycle a response retires.
- rspReady while rspValid low, or from the non-granted port: ignored.
- Valid dropped before ready: no handshake, no state change; prio unchanged.
- Flags with setFlags=0: dataOutFlags unchanged; dataOutRspFlags still reports the op's flags.
- ALU drive regs hold last issued values outside EXEC (no toggling when idle).
- Reset (any state, incl. mid-EXEC/RESP): state IDLE, in-flight op dropped with no response, prio=RST_PRIO, all outputs 0 (ALU drive regs, result, rsp flags, dataOutFlags, rspValid, busy). Ready low during reset cycle.

Test Plan:
- Reset then single req on port 0 (A=5, B=3, op=1, setFlags=1), ALU stub returns 8, flags 0000 -> ready0 at cycle 0, ALU pins A=5/B=3/op=1 at cycle 1, rspValid0 at cycle 2 with result 8; dataOutFlags=0000.
- Both valid every cycle, rspReady tied high -> grants alternate 0,1,0,1 (RST_PRIO=0); each op 3 cycles; ready never both high.
- Port 1 op with setFlags=0 and ALU stub Z=1,N=0,C=1,V=0 -> dataOutRspFlags=4'b0110, dataOutFlags holds prior value.
- Response backpressure: rspReady0 low 5 cycles -> rspValid0, result, flags stable 5 cycles; ready0/ready1 stay low; retire on 6th cycle, IDLE next.
- rst asserted in EXEC -> next cycle all outputs 0, no rspValid ever for that op; new request accepted immediately after rst drops.
- rspReady1 asserted while port 0's response pending -> ignored; rspValid0 held until rspReady0.
